// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor, one carry chunk per stage
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < STAGES || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic advance;
    logic accept;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int BW = WIDTH - LO;

        // acc carries finished sum chunks below LO and untouched A chunks from LO upward
        logic [WIDTH-1:0] acc_in;
        logic [BW-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] acc_d, acc_q;
        logic             carry_d, carry_q;
        logic             valid_d, valid_q;

        if (k == 0) begin : g_head
            assign acc_in = a;
            assign b_in   = op ? ~b : b;
            assign c_in   = op | cin;
            assign v_in   = accept;
        end else begin : g_link
            assign acc_in = g_stage[k-1].acc_q;
            assign b_in   = g_stage[k-1].g_mid.b_q;
            assign c_in   = g_stage[k-1].carry_q;
            assign v_in   = g_stage[k-1].valid_q;
        end

        always_comb begin
            part    = {1'b0, acc_in[LO +: CHUNK]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
            acc_d   = acc_in;
            acc_d[LO +: CHUNK] = part[CHUNK-1:0];
            carry_d = part[CHUNK];
            valid_d = v_in;
        end

        // Data only loads with a real token so bubbles leave the last result on the outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                acc_q   <= '0;
                carry_q <= 1'b0;
            end else if (advance) begin
                valid_q <= valid_d;
                if (v_in) begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [BW-CHUNK-1:0] b_d, b_q;

            always_comb b_d = b_in[BW-1:CHUNK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (advance && v_in) begin
                    b_q <= b_d;
                end
            end
        end else begin : g_tail
            logic ovf_d, ovf_q;

            // carry into the MSB recovered from the MSB sum bit and its operands
            always_comb ovf_d = (part[CHUNK-1] ^ acc_in[WIDTH-1] ^ b_in[CHUNK-1]) ^ part[CHUNK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].acc_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed and model-checked bench for pipelined_addsub
module tb_pipelined_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        rst_x;
    logic        in_valid_7, in_ready_7, cin_7, op_7, out_valid_7, out_ready_7, cout_7, ovf_7;
    logic [6:0]  a_7, b_7, sum_7;
    logic        in_valid_12, in_ready_12, cin_12, op_12, out_valid_12, out_ready_12, cout_12, ovf_12;
    logic [11:0] a_12, b_12, sum_12;

    int n_checks = 0;
    int n_fail   = 0;
    bit done7    = 1'b0;
    bit done12   = 1'b0;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(7), .STAGES(1)) dut7 (
        .clk(clk), .rst(rst_x), .in_valid(in_valid_7), .in_ready(in_ready_7), .a(a_7), .b(b_7),
        .cin(cin_7), .op(op_7), .out_valid(out_valid_7), .out_ready(out_ready_7), .sum(sum_7),
        .cout(cout_7), .ovf(ovf_7)
    );

    pipelined_addsub #(.WIDTH(12), .STAGES(3)) dut12 (
        .clk(clk), .rst(rst_x), .in_valid(in_valid_12), .in_ready(in_ready_12), .a(a_12), .b(b_12),
        .cin(cin_12), .op(op_12), .out_valid(out_valid_12), .out_ready(out_ready_12), .sum(sum_12),
        .cout(cout_12), .ovf(ovf_12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic and the sign rule for overflow
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic opv);
        longint unsigned mask, aa, bb, full;
        logic [31:0] s;
        logic sa, sb, ss, co, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, av};
        bb   = {32'd0, bv};
        if (opv) bb = ~bb & mask;
        full = aa + bb + ((opv || ci) ? 64'd1 : 64'd0);
        s    = 32'(full & mask);
        co   = ((full >> w) & 64'd1) != 0;
        sa   = av[w-1];
        sb   = bv[w-1];
        ss   = s[w-1];
        ov   = opv ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
        return {ov, co, s};
    endfunction

    typedef struct {
        logic [15:0] a, b;
        logic        cin, op;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;

    localparam int NV  = 11;
    localparam int LAT = 4;
    vec_t vt [NV];

    logic [15:0] ra [8], rb [8];
    logic        rc [8], ro [8];
    logic [33:0] expq [$];
    logic [33:0] e;
    int issued, got;

    initial begin : main
        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Table vectors back to back; results must appear exactly LAT cycles after issue
        for (int i = 0; i < NV + LAT; i++) begin
            @(negedge clk);
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            chk("tbl_out_valid", 32'(out_valid), (i >= LAT) ? 32'd1 : 32'd0);
            if (i >= LAT) begin
                chk("tbl_sum", 32'(sum), 32'(vt[i-LAT].s));
                chk("tbl_cout", 32'(cout), 32'(vt[i-LAT].co));
                chk("tbl_ovf", 32'(ovf), 32'(vt[i-LAT].ov));
            end
            if (i < NV) begin
                in_valid = 1'b1; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; op = vt[i].op;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("tbl_drained", 32'(out_valid), 32'd0);

        // 8 random ops with a 3-cycle consumer stall while the pipe is full
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom); rb[i] = 16'($urandom);
            rc[i] = 1'($urandom); ro[i] = 1'($urandom);
        end
        issued = 0; got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = (issued < 8);
            if (in_valid) begin
                a = ra[issued]; b = rb[issued]; cin = rc[issued]; op = ro[issued];
            end
            #1;
            chk("stall_in_ready", 32'(in_ready), (c >= 6 && c <= 8) ? 32'd0 : 32'd1);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("stall_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("stall_sum", 32'(sum), expq[0][31:0]);
                    chk("stall_cout", 32'(cout), 32'(expq[0][32]));
                    chk("stall_ovf", 32'(ovf), 32'(expq[0][33]));
                    if (out_ready) begin
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(16, {16'd0, a}, {16'd0, b}, cin, op));
                issued++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_results_count", 32'(got), 32'd8);

        // Reset with three ops in flight: none may emerge, a fresh op still takes 4 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0; op = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = 16'h00F0; b = 16'h0F10; cin = 1'b0; op = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("rst_new_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) begin
                chk("rst_new_sum", 32'(sum), 32'h1000);
                chk("rst_new_cout", 32'(cout), 32'd0);
                chk("rst_new_ovf", 32'(ovf), 32'd0);
            end
        end

        for (int t = 0; t < 70000 && !(done7 && done12); t++) @(negedge clk);
        chk("aux_streams_done", 32'(done7 && done12), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // WIDTH=7 STAGES=1: every a, b, cin, op combination, latency 1
    initial begin : aux7
        logic [15:0] jv;
        logic [33:0] e7;
        rst_x = 1'b1; in_valid_7 = 1'b0; out_ready_7 = 1'b1;
        a_7 = '0; b_7 = '0; cin_7 = 1'b0; op_7 = 1'b0;
        repeat (2) @(negedge clk);
        rst_x = 1'b0;
        for (int i = 0; i <= 65536; i++) begin
            @(negedge clk);
            chk("w7_in_ready", 32'(in_ready_7), 32'd1);
            chk("w7_out_valid", 32'(out_valid_7), (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) begin
                jv = 16'(i - 1);
                e7 = model(7, {25'd0, jv[6:0]}, {25'd0, jv[13:7]}, jv[14], jv[15]);
                chk("w7_sum", 32'(sum_7), e7[31:0]);
                chk("w7_cout", 32'(cout_7), 32'(e7[32]));
                chk("w7_ovf", 32'(ovf_7), 32'(e7[33]));
            end
            if (i < 65536) begin
                jv = 16'(i);
                in_valid_7 = 1'b1; a_7 = jv[6:0]; b_7 = jv[13:7]; cin_7 = jv[14]; op_7 = jv[15];
            end else begin
                in_valid_7 = 1'b0;
            end
        end
        done7 = 1'b1;
    end

    // WIDTH=12 STAGES=3: 1000 random ops streamed against the model
    initial begin : aux12
        logic [33:0] q12 [$];
        logic [33:0] e12;
        in_valid_12 = 1'b0; out_ready_12 = 1'b1;
        a_12 = '0; b_12 = '0; cin_12 = 1'b0; op_12 = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 1000 + 3; i++) begin
            @(negedge clk);
            chk("w12_out_valid", 32'(out_valid_12), (i >= 3) ? 32'd1 : 32'd0);
            if (i >= 3 && q12.size() > 0) begin
                e12 = q12.pop_front();
                chk("w12_sum", 32'(sum_12), e12[31:0]);
                chk("w12_cout", 32'(cout_12), 32'(e12[32]));
                chk("w12_ovf", 32'(ovf_12), 32'(e12[33]));
            end
            if (i < 1000) begin
                in_valid_12 = 1'b1;
                a_12 = 12'($urandom); b_12 = 12'($urandom);
                cin_12 = 1'($urandom); op_12 = 1'($urandom);
                q12.push_back(model(12, {20'd0, a_12}, {20'd0, b_12}, cin_12, op_12));
            end else begin
                in_valid_12 = 1'b0;
            end
        end
        done12 = 1'b1;
    end

endmodule
